// File: rtl/wavelet_pkg.sv
// wavelet_pkg: shared defaults, channel indices and
// stage phase type for the multi-level Haar transform.
package wavelet_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEVELS = 3;
  localparam int DEF_SEL_W  = 8;
  localparam int MAX_LEVELS = 6;
  localparam int CH_RAW     = 0;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_e;

  function automatic int ch_approx(input int levels);
    return levels + 1;
  endfunction

endpackage

// File: rtl/wavelet_transform_multilevel_if.sv
// wavelet_transform_multilevel_if: sample, control
// and multiplexed-output pins of the transform.
interface wavelet_transform_multilevel_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 8
);

  logic              i_data_clk;
  logic [DATA_W-1:0] i_value;
  logic              i_flush;
  logic [SEL_W-1:0]  i_select_output_channel;
  logic [DATA_W-1:0] o_multiplexed_wavelet_out;
  logic              o_valid;
  logic              o_active;

  modport master (
    output i_data_clk,
    output i_value,
    output i_flush,
    output i_select_output_channel,
    input  o_multiplexed_wavelet_out,
    input  o_valid,
    input  o_active
  );

  modport slave (
    input  i_data_clk,
    input  i_value,
    input  i_flush,
    input  i_select_output_channel,
    output o_multiplexed_wavelet_out,
    output o_valid,
    output o_active
  );

endinterface

// File: rtl/haar_stage.sv
// haar_stage: pairs successive samples into a floor
// average and a halved signed difference.
module haar_stage
  import wavelet_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              flush,
  input  logic              in_stb,
  input  logic [DATA_W-1:0] in_val,
  output logic [DATA_W-1:0] approx,
  output logic [DATA_W-1:0] detail,
  output logic              approx_stb
);

  phase_e phase_q, phase_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] approx_q, approx_d;
  logic [DATA_W-1:0] detail_q, detail_d;
  logic              stb_q, stb_d;

  logic        [DATA_W:0] sum;
  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] dsh;

  always_comb begin
    phase_d  = phase_q;
    a_d      = a_q;
    approx_d = approx_q;
    detail_d = detail_q;
    stb_d    = 1'b0;
    sum  = {1'b0, a_q} + {1'b0, in_val};
    diff = $signed({1'b0, in_val}) - $signed({1'b0, a_q});
    dsh  = diff >>> 1;
    if (flush) begin
      phase_d = EVEN;
    end else if (in_stb) begin
      unique case (phase_q)
        EVEN: begin
          a_d     = in_val;
          phase_d = ODD;
        end
        ODD: begin
          approx_d = DATA_W'(sum >> 1);
          detail_d = DATA_W'(dsh);
          stb_d    = 1'b1;
          phase_d  = EVEN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      phase_q  <= EVEN;
      a_q      <= '0;
      approx_q <= '0;
      detail_q <= '0;
      stb_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      a_q      <= a_d;
      approx_q <= approx_d;
      detail_q <= detail_d;
      stb_q    <= stb_d;
    end
  end

  assign approx     = approx_q;
  assign detail     = detail_q;
  assign approx_stb = stb_q;

endmodule

// File: rtl/wavelet_transform_multilevel.sv
// wavelet_transform_multilevel: strobe synchroniser,
// LEVELS cascaded Haar stages and a registered channel mux.
module wavelet_transform_multilevel
  import wavelet_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEVELS = DEF_LEVELS,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic                          clk,
  input  logic                          resetb,
  wavelet_transform_multilevel_if.slave io
);

  logic [2:0] sync_q, sync_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              active_q, active_d;

  logic [LEVELS:0]              stb;
  logic [LEVELS:0][DATA_W-1:0] app;
  logic [LEVELS:1][DATA_W-1:0] det;
  logic [LEVELS:1]              stb_raw;

  logic              sel_stb;
  logic [DATA_W-1:0] sel_val;
  logic [SEL_W-1:0]  sel;

  assign sel    = io.i_select_output_channel;
  assign sync_d = {sync_q[1:0], io.i_data_clk};
  // A flush in the same cycle discards the sample.
  assign stb[0] = sync_q[1] & ~sync_q[2] & ~io.i_flush;
  assign app[0] = io.i_value;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
    haar_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk       (clk),
      .resetb    (resetb),
      .flush     (io.i_flush),
      .in_stb    (stb[k-1]),
      .in_val    (app[k-1]),
      .approx    (app[k]),
      .detail    (det[k]),
      .approx_stb(stb_raw[k])
    );
    assign stb[k] = stb_raw[k] & ~io.i_flush;
  end

  always_comb begin
    sel_stb = 1'b0;
    sel_val = '0;
    if (sel == SEL_W'(CH_RAW)) begin
      sel_stb = stb[0];
      sel_val = app[0];
    end else if (sel == SEL_W'(ch_approx(LEVELS))) begin
      sel_stb = stb[LEVELS];
      sel_val = app[LEVELS];
    end else begin
      for (int k = 1; k <= LEVELS; k++) begin
        if (sel == SEL_W'(k)) begin
          sel_stb = stb[k];
          sel_val = det[k];
        end
      end
    end
  end

  always_comb begin
    out_d    = out_q;
    valid_d  = sel_stb;
    active_d = active_q;
    if (sel_stb) out_d = sel_val;
    if (sel > SEL_W'(ch_approx(LEVELS))) out_d = '0;
    if (io.i_flush) active_d = 1'b0;
    else if (stb[LEVELS]) active_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q   <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  assign io.o_multiplexed_wavelet_out = out_q;
  assign io.o_valid                   = valid_q;
  assign io.o_active                  = active_q;

endmodule

// File: tb/tb_wavelet_transform_multilevel.sv
// tb_wavelet_transform_multilevel: directed vectors for
// the 3-level, 8-bit configuration.
module tb_wavelet_transform_multilevel;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   vcnt = 0;

  wavelet_transform_multilevel_if #(.DATA_W(8), .SEL_W(8)) io ();

  wavelet_transform_multilevel #(
    .DATA_W(8),
    .LEVELS(3),
    .SEL_W (8)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .io    (io)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (io.o_valid) vcnt++;

  task automatic do_reset();
    @(negedge clk);
    resetb = 1'b0;
    io.i_data_clk = 1'b0;
    io.i_flush = 1'b0;
    io.i_value = '0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    io.i_value = v;
    io.i_data_clk = 1'b1;
    repeat (4) @(negedge clk);
    io.i_data_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic strobe_timed(input logic [7:0] v, output int vat);
    @(negedge clk);
    io.i_value = v;
    io.i_data_clk = 1'b1;
    vat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (io.o_valid && vat == 0) vat = i;
    end
    @(negedge clk);
    io.i_data_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    io.i_select_output_channel = 8'd0;
    do_reset();
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd0 || io.o_valid !== 1'b0
        || io.o_active !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: out=%0d valid=%b active=%b want 0/0/0",
               io.o_multiplexed_wavelet_out, io.o_valid, io.o_active);
    end
  endtask

  task automatic test_raw();
    int vat, v0;
    do_reset();
    io.i_select_output_channel = 8'd0;
    v0 = vcnt;
    strobe(8'd10);
    strobe_timed(8'd20, vat);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd20) begin
      fails++;
      $display("FAIL raw_value: got %0d want 20", io.o_multiplexed_wavelet_out);
    end
    tests++;
    if (vat !== 3) begin
      fails++;
      $display("FAIL raw_latency: valid at edge %0d want 3", vat);
    end
    tests++;
    if (vcnt - v0 !== 2) begin
      fails++;
      $display("FAIL raw_valid_count: got %0d want 2", vcnt - v0);
    end
  endtask

  task automatic test_detail();
    int vat, v0;
    do_reset();
    io.i_select_output_channel = 8'd1;
    strobe(8'd10);
    strobe_timed(8'd20, vat);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd5) begin
      fails++;
      $display("FAIL detail_value: got %0d want 5", io.o_multiplexed_wavelet_out);
    end
    tests++;
    if (vat !== 4) begin
      fails++;
      $display("FAIL detail_latency: valid at edge %0d want 4", vat);
    end
    v0 = vcnt;
    io.i_select_output_channel = 8'd0;
    repeat (4) @(negedge clk);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd5 || vcnt != v0) begin
      fails++;
      $display("FAIL select_change_hold: out=%0d pulses=%0d want 5/0",
               io.o_multiplexed_wavelet_out, vcnt - v0);
    end
  endtask

  task automatic test_negative();
    int v0;
    do_reset();
    io.i_select_output_channel = 8'd1;
    strobe(8'd200);
    strobe(8'd100);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'hCE) begin
      fails++;
      $display("FAIL negative_detail: got %h want ce", io.o_multiplexed_wavelet_out);
    end
    v0 = vcnt;
    io.i_select_output_channel = 8'd4;
    repeat (8) @(negedge clk);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'hCE || vcnt != v0
        || io.o_active !== 1'b0) begin
      fails++;
      $display("FAIL approx_idle: out=%h pulses=%0d active=%b want ce/0/0",
               io.o_multiplexed_wavelet_out, vcnt - v0, io.o_active);
    end
  endtask

  task automatic test_cascade();
    int v0;
    do_reset();
    io.i_select_output_channel = 8'd4;
    v0 = vcnt;
    for (int i = 0; i < 7; i++) strobe(8'(i));
    repeat (6) @(negedge clk);
    tests++;
    if (io.o_active !== 1'b0) begin
      fails++;
      $display("FAIL active_early: got %b want 0 after 7 samples", io.o_active);
    end
    strobe(8'd7);
    repeat (4) @(negedge clk);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd3 || io.o_active !== 1'b1) begin
      fails++;
      $display("FAIL final_approx: out=%0d active=%b want 3/1",
               io.o_multiplexed_wavelet_out, io.o_active);
    end
    tests++;
    if (vcnt - v0 !== 1) begin
      fails++;
      $display("FAIL approx_valid_count: got %0d want 1", vcnt - v0);
    end
    io.i_select_output_channel = 8'd3;
    for (int i = 0; i < 8; i++) strobe(8'(i));
    repeat (4) @(negedge clk);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd2) begin
      fails++;
      $display("FAIL level3_detail: got %0d want 2", io.o_multiplexed_wavelet_out);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    io.i_select_output_channel = 8'd4;
    for (int i = 0; i < 8; i++) strobe(8'd255);
    repeat (4) @(negedge clk);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd255) begin
      fails++;
      $display("FAIL approx_no_overflow: got %0d want 255", io.o_multiplexed_wavelet_out);
    end
    io.i_select_output_channel = 8'd1;
    strobe(8'd255);
    strobe(8'd255);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd0) begin
      fails++;
      $display("FAIL detail_equal: got %0d want 0", io.o_multiplexed_wavelet_out);
    end
    strobe(8'd0);
    strobe(8'd255);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd127) begin
      fails++;
      $display("FAIL detail_max: got %0d want 127", io.o_multiplexed_wavelet_out);
    end
  endtask

  task automatic test_flush();
    do_reset();
    io.i_select_output_channel = 8'd1;
    for (int i = 0; i < 8; i++) strobe(8'(i));
    repeat (4) @(negedge clk);
    strobe(8'd1);
    strobe(8'd5);
    strobe(8'd3);
    @(negedge clk);
    io.i_flush = 1'b1;
    @(negedge clk);
    io.i_flush = 1'b0;
    @(negedge clk);
    tests++;
    if (io.o_active !== 1'b0 || io.o_multiplexed_wavelet_out !== 8'd2) begin
      fails++;
      $display("FAIL flush_state: active=%b out=%0d want 0/2",
               io.o_active, io.o_multiplexed_wavelet_out);
    end
    strobe(8'd40);
    strobe(8'd60);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd10) begin
      fails++;
      $display("FAIL flush_repair: got %0d want 10", io.o_multiplexed_wavelet_out);
    end
  endtask

  task automatic test_edge_cases();
    int v0;
    do_reset();
    io.i_select_output_channel = 8'd0;
    v0 = vcnt;
    @(negedge clk);
    io.i_value = 8'd77;
    io.i_data_clk = 1'b1;
    repeat (2) @(negedge clk);
    io.i_flush = 1'b1;
    @(negedge clk);
    io.i_flush = 1'b0;
    repeat (2) @(negedge clk);
    io.i_data_clk = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd0 || vcnt != v0) begin
      fails++;
      $display("FAIL flush_drop_raw: out=%0d pulses=%0d want 0/0",
               io.o_multiplexed_wavelet_out, vcnt - v0);
    end
    io.i_select_output_channel = 8'd1;
    strobe(8'd30);
    strobe(8'd50);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd10) begin
      fails++;
      $display("FAIL flush_drop_pair: got %0d want 10", io.o_multiplexed_wavelet_out);
    end
    strobe(8'd11);
    #2;
    resetb = 1'b0;
    #1;
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd0 || io.o_valid !== 1'b0
        || io.o_active !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: out=%0d valid=%b active=%b want 0/0/0",
               io.o_multiplexed_wavelet_out, io.o_valid, io.o_active);
    end
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    strobe(8'd20);
    strobe(8'd30);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd5) begin
      fails++;
      $display("FAIL reset_phase: got %0d want 5", io.o_multiplexed_wavelet_out);
    end
    io.i_select_output_channel = 8'd9;
    repeat (2) @(negedge clk);
    v0 = vcnt;
    for (int i = 0; i < 8; i++) strobe(8'(i + 1));
    repeat (4) @(negedge clk);
    tests++;
    if (io.o_multiplexed_wavelet_out !== 8'd0 || vcnt != v0) begin
      fails++;
      $display("FAIL bad_select: out=%0d pulses=%0d want 0/0",
               io.o_multiplexed_wavelet_out, vcnt - v0);
    end
  endtask

  initial begin
    io.i_data_clk = 1'b0;
    io.i_value = '0;
    io.i_flush = 1'b0;
    io.i_select_output_channel = '0;
    test_reset();
    test_raw();
    test_detail();
    test_negative();
    test_cascade();
    test_extremes();
    test_flush();
    test_edge_cases();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
